// File: rtl/div_unit.sv
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
//                Produces quotient (LO) and remainder (HI), one quotient bit
//                per clock, with busy/ready handshake toward the hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 cancel,
    input  logic [DIV_WIDTH-1:0] a,
    input  logic [DIV_WIDTH-1:0] b,
    output logic                 busy,
    output logic                 ready,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(DIV_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   dvd_q, dvd_d;     // dividend magnitude, becomes quotient as it shifts
    logic [DIV_WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
    logic [DIV_WIDTH-1:0]   pr_q, pr_d;       // partial remainder (always < divisor)
    logic                   qsign_q, qsign_d;
    logic                   rsign_q, rsign_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;
    logic [DIV_WIDTH-1:0]   quot_q, quot_d;
    logic [DIV_WIDTH-1:0]   rem_q, rem_d;

    logic [DIV_WIDTH-1:0]   a_mag, b_mag;
    logic [DIV_WIDTH:0]     diff;
    logic [DIV_WIDTH-1:0]   shifted_lo;
    logic [DIV_WIDTH-1:0]   pr_next;
    logic [DIV_WIDTH-1:0]   q_next;

    // Operand magnitudes; only DIV treats the MSB as a sign bit.
    always_comb begin
        a_mag = (signed_div && a[DIV_WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag = (signed_div && b[DIV_WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // One restoring step: shift in the next dividend bit and try a subtract.
    // The partial remainder stays below the divisor, so after the shift the
    // low DIV_WIDTH bits hold the whole value whenever the subtract fails.
    always_comb begin
        diff       = {pr_q, dvd_q[DIV_WIDTH-1]} - {1'b0, dvs_q};
        shifted_lo = {pr_q[DIV_WIDTH-2:0], dvd_q[DIV_WIDTH-1]};
        pr_next    = diff[DIV_WIDTH] ? shifted_lo : diff[DIV_WIDTH-1:0];
        q_next     = {dvd_q[DIV_WIDTH-2:0], ~diff[DIV_WIDTH]};
    end

    // Next-state and next-output logic for the divider FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    qsign_d = signed_div & (a[DIV_WIDTH-1] ^ b[DIV_WIDTH-1]);
                    rsign_d = signed_div & a[DIV_WIDTH-1];
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    pr_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    if (b == '0) begin
                        // Divide-by-zero skips the iterations entirely.
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = a;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    pr_d  = pr_next;
                    dvd_d = q_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_LAST_ITER) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                        quot_d  = qsign_q ? (~q_next + 1'b1) : q_next;
                        rem_d   = rsign_q ? (~pr_next + 1'b1) : pr_next;
                    end
                end
            end
            ST_DONE: begin
                // Cancel or not, DONE always falls back to IDLE.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy      = busy_q;
    assign ready     = ready_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit. A transaction-level model
//                (plain 64-bit arithmetic plus an edge countdown) predicts
//                busy/ready/quotient/remainder every cycle; directed cases
//                pin the model with hand-computed literals.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    div_unit #(.DIV_WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .cancel     (cancel),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .ready      (ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference division from plain integer arithmetic.
    function automatic void ref_div(input bit s, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sx, sy;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else begin
            if (s) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
            end else begin
                sx = longint'({32'd0, x});
                sy = longint'({32'd0, y});
            end
            q = 32'(sx / sy);
            r = 32'(sx % sy);
        end
    endfunction

    // Transaction-level model: phase 0 idle, 1 running, 2 result cycle.
    int          m_phase;
    int          m_left;
    logic [31:0] m_pq, m_pr;
    logic        m_busy, m_ready;
    logic [31:0] m_q, m_r;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase = 0; m_left = 0;
            m_busy = 1'b0; m_ready = 1'b0;
            m_q = 32'd0; m_r = 32'd0;
        end else begin
            case (m_phase)
                0: begin
                    m_ready = 1'b0;
                    if (start && !cancel) begin
                        ref_div(signed_div, a, b, m_pq, m_pr);
                        m_busy = 1'b1;
                        if (b == 32'd0) begin
                            m_q = m_pq; m_r = m_pr; m_ready = 1'b1; m_phase = 2;
                        end else begin
                            m_left = 32; m_phase = 1;
                        end
                    end
                end
                1: begin
                    if (cancel) begin
                        m_phase = 0; m_busy = 1'b0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_q = m_pq; m_r = m_pr; m_ready = 1'b1; m_phase = 2;
                        end
                    end
                end
                default: begin
                    m_phase = 0; m_busy = 1'b0; m_ready = 1'b0;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy",      {31'd0, busy},  {31'd0, m_busy});
            chk("cyc_ready",     {31'd0, ready}, {31'd0, m_ready});
            chk("cyc_quotient",  quotient,  m_q);
            chk("cyc_remainder", remainder, m_r);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit s, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; signed_div = s; a = x; b = y;
        step();
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 40) begin
            step();
            cyc++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string nm, input bit s, input logic [31:0] x, input logic [31:0] y,
                          input int lat, input logic [31:0] eq, input logic [31:0] er);
        int cyc;
        issue(s, x, y);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
        wait_ready(cyc);
        chk({nm, "_lat"}, 32'(cyc), 32'(lat));
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
        step();
        chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int rdy_cnt, cyc;
        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0;
        a = 32'd0; b = 32'd0;
        repeat (3) step();
        cmp_en = 1'b1;
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_q", quotient,  32'd0);
        chk("rst_r", remainder, 32'd0);
        @(negedge clk); #2 resetn = 1'b1;
        step();

        run_op("u100_7",  1'b0, 32'd100,        32'd7,          32, 32'd14,        32'd2);
        run_op("sm7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          32, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("s7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE,  32, 32'hFFFF_FFFD, 32'd1);
        run_op("s_ovf",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32, 32'h8000_0000, 32'd0);
        run_op("u_big",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32, 32'd0,         32'h8000_0000);
        run_op("dz_u",    1'b0, 32'h0000_1234,  32'd0,           0, 32'hFFFF_FFFF, 32'h0000_1234);
        run_op("dz_s",    1'b1, 32'h0000_1234,  32'd0,           0, 32'hFFFF_FFFF, 32'h0000_1234);

        // Cancel ten cycles in: no ready, results keep the last completion.
        issue(1'b0, 32'd50, 32'd5);
        repeat (9) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        rdy_cnt = 0;
        for (int i = 0; i < 35; i++) begin
            if (ready) rdy_cnt++;
            step();
        end
        chk("cancel_no_ready", 32'(rdy_cnt), 32'd0);
        chk("cancel_q", quotient,  32'hFFFF_FFFF);
        chk("cancel_r", remainder, 32'h0000_1234);

        // Re-issue with a stray start pulse mid-operation.
        issue(1'b0, 32'd100, 32'd10);
        repeat (4) step();
        start = 1'b1; a = 32'd1000; b = 32'd3;
        step();
        start = 1'b0;
        wait_ready(cyc);
        chk("reissue_lat", 32'(cyc), 32'd27);
        chk("reissue_q", quotient,  32'd10);
        chk("reissue_r", remainder, 32'd0);
        step();

        // Asynchronous reset between edges, mid-operation.
        issue(1'b0, 32'd50, 32'd7);
        repeat (5) step();
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy",  {31'd0, busy},  32'd0);
        chk("arst_ready", {31'd0, ready}, 32'd0);
        chk("arst_q", quotient,  32'd0);
        chk("arst_r", remainder, 32'd0);
        @(negedge clk); #2 resetn = 1'b1;
        step();
        run_op("post_rst_9_3", 1'b0, 32'd9, 32'd3, 32, 32'd3, 32'd0);

        // Randomized traffic: start/cancel/operands change every cycle.
        for (int i = 0; i < 3000; i++) begin
            start      = ($urandom_range(0, 9) == 0);
            cancel     = ($urandom_range(0, 59) == 0);
            signed_div = 1'($urandom_range(0, 1));
            a          = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = $urandom; end
                4:       a = $urandom_range(0, 255);
                default: b = $urandom;
            endcase
            if (b == 32'd0 && $urandom_range(0, 3) != 0) b = 32'd1;
            step();
        end
        start = 1'b0; cancel = 1'b0;
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for MIPS DIV/DIVU, alongside the combinational ALU in the EX stage.
- Takes signed or unsigned operands and produces the quotient (for LO) and remainder (for HI).
- Iterates with a radix-2 restoring algorithm, one bit per clock.
- Holds `busy` high so the hazard unit can stall the pipeline until `ready`.

Parameters:
- DIV_WIDTH, 32, operand and result width. Only 32 is verified.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a division; sampled only in IDLE.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- cancel  in  1  synchronous abort (exception/flush).
- a  in  32  dividend; sampled with start.
- b  in  32  divisor; sampled with start.
- busy  out  1  high while a division is in progress (states BUSY and DONE).
- ready  out  1  one-cycle pulse; quotient/remainder are valid this cycle.
- quotient  out  32  result for LO; holds its last value until the next completion.
- remainder  out  32  result for HI; holds its last value until the next completion.

Behaviour:
- Reset (resetn low, asynchronous): state = IDLE; busy = 0, ready = 0; quotient = 0, remainder = 0; counter = 0. Takes effect immediately, including mid-operation.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start = 1 and cancel = 0 latches |a|, |b|, the quotient sign (a[31]^b[31]) and the remainder sign (a[31]). Magnitudes and signs are taken only when signed_div = 1; otherwise the raw values are used.
  - b != 0: next state BUSY, counter = 0.
  - b == 0: next state DONE, quotient = 32'hFFFFFFFF, remainder = a (raw value, both modes).
- BUSY, one iteration per edge:
  - partial remainder = {partial remainder[31:0], dividend MSB}, 33 bits.
  - Subtract the divisor magnitude from it.
  - Result non-negative: keep the difference and shift 1 into the quotient.
  - Otherwise: keep the old value and shift 0 into the quotient.
  - counter increments each edge. On the edge where counter == 31, the last iteration completes and the sign-corrected results are registered into quotient/remainder; next state DONE.
    - Quotient is negated if its sign = 1.
    - Remainder is negated if its sign = 1, so the remainder takes the sign of the dividend.
- DONE: ready = 1 for exactly one cycle; next edge returns to IDLE.
- Latency:
  - Normal division: start sampled at edge E0; ready is high in the cycle after E32, i.e. 32 cycles after the start cycle.
  - Divide-by-zero: ready is high in the cycle after E0.
- busy is high from the cycle after start through the ready cycle inclusive, and low in IDLE.
- start while in BUSY or DONE: ignored, with no effect on the operation in flight.
- cancel:
  - In BUSY or DONE, the next state is IDLE. ready does not pulse (a cancel during the DONE cycle still lets the current ready cycle show, but forces IDLE).
  - quotient/remainder keep their previous completed values, except when cancel hits during DONE, where the new values remain.
  - cancel and start together in IDLE: cancel wins and nothing starts.
- Signed overflow (0x80000000 / 0xFFFFFFFF): falls out of the magnitude algorithm as quotient = 0x80000000, remainder = 0. No flag.
- Operands change after the start cycle: no effect; only the latched copies are used.

Test Plan:
- Unsigned: signed_div = 0, a = 100, b = 7, start pulse -> busy high next cycle; ready exactly 32 cycles after the start cycle; quotient = 14, remainder = 2; busy low the cycle after ready.
- Signed negative: signed_div = 1, a = 0xFFFFFFF9 (-7), b = 2 -> quotient = 0xFFFFFFFD (-3), remainder = 0xFFFFFFFF (-1). Also a = 7, b = 0xFFFFFFFE -> quotient = 0xFFFFFFFD, remainder = 1.
- Overflow and large unsigned:
  - signed_div = 1, a = 0x80000000, b = 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0.
  - signed_div = 0, same operands -> quotient = 0, remainder = 0x80000000.
- Divide-by-zero: a = 0x00001234, b = 0, either mode -> ready in the cycle after the start cycle; quotient = 0xFFFFFFFF, remainder = 0x00001234.
- Cancel and re-issue:
  - Start 50/5, assert cancel 10 cycles later -> busy low the next cycle; no ready pulse; quotient/remainder unchanged.
  - Then start 100/10 -> quotient = 10, remainder = 0 after 32 cycles.
  - A start pulse mid-operation leaves the result unchanged.
- Reset mid-operation: resetn low 5 cycles into a division, asynchronously between edges -> busy, ready, quotient and remainder go to 0 immediately. After release, a new start 9/3 gives quotient = 3, remainder = 0.
